// File: rtl/freq_div_prog.sv
// Runtime-programmable, multi-channel 50%-duty clock divider with glitch-free ratio updates.
// Optional per-channel completed-period counters (per_cnt) are enabled by defining FREQ_DIV_PERIOD_CNT_EN.
module freq_div_prog #(
   parameter int  CH      = 4,
   parameter int  W       = 8,
   parameter int  DEF_DIV = 2,
   localparam int CW      = $clog2(CH)
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [CH-1:0]   ch_en,
   input  logic            cfg_valid,
   input  logic [CW-1:0]   cfg_ch,
   input  logic [W-1:0]    cfg_div,
   output logic            cfg_ready,
   output logic            cfg_err,
   output logic [CH-1:0]   div_out,
   output logic [CH-1:0]   tick,
   output logic [CH-1:0]   running
`ifdef FREQ_DIV_PERIOD_CNT_EN
   ,
   output logic [CH*16-1:0] per_cnt
`endif
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2
   } state_t;

   localparam logic [W-1:0] DIV_MIN = W'(2);
   localparam logic [W-1:0] ONE_W   = W'(1);
   localparam logic [W:0]   ONE_W1  = (W+1)'(1);
   localparam logic [W-1:0] DIV_RST = W'(DEF_DIV);

   state_t        r_state    [CH];
   logic [W-1:0]  r_cnt      [CH];
   logic [W-1:0]  r_ratio    [CH];
   logic [W-1:0]  r_pend_div [CH];
   logic [CH-1:0] r_pending;
   logic [CH-1:0] r_q_p;
   logic [CH-1:0] r_q_n;
   logic [CH-1:0] r_tick;
   logic [CH-1:0] r_run;
   logic          r_cfg_err;

   state_t        w_state_nxt [CH];
   logic [W-1:0]  w_cnt_nxt   [CH];
   logic [W-1:0]  w_ratio_nxt [CH];
   logic [W-1:0]  w_pdiv_nxt  [CH];
   logic [W:0]    w_half      [CH];
   logic [CH-1:0] w_pend_nxt;
   logic [CH-1:0] w_q_p_nxt;
   logic [CH-1:0] w_tick_nxt;
   logic [CH-1:0] w_run_nxt;
   logic [CH-1:0] w_acc;
   logic [CH-1:0] w_wrap;
   logic          w_ch_ok;
   logic          w_cfg_short;
   logic          w_accept;
   logic [W-1:0]  w_cfg_val;

   // Config handshake: out-of-range channels are always ready and silently dropped.
   always_comb begin
      w_ch_ok     = (int'(cfg_ch) < CH);
      w_cfg_short = (cfg_div < DIV_MIN);
      if (w_cfg_short) begin
         w_cfg_val = DIV_MIN;
      end else begin
         w_cfg_val = cfg_div;
      end
      if (w_ch_ok) begin
         cfg_ready = ~r_pending[cfg_ch];
      end else begin
         cfg_ready = 1'b1;
      end
      w_accept = cfg_valid & cfg_ready & w_ch_ok;
   end

   // Per-channel next state; ratio changes only at a wrap so no period is truncated.
   always_comb begin
      for (int i = 0; i < CH; i++) begin
         w_state_nxt[i] = r_state[i];
         w_cnt_nxt[i]   = r_cnt[i];
         w_ratio_nxt[i] = r_ratio[i];
         w_pdiv_nxt[i]  = r_pend_div[i];
         w_pend_nxt[i]  = r_pending[i];
         w_acc[i]       = w_accept & (cfg_ch == CW'(i));
         w_wrap[i]      = (r_cnt[i] == (r_ratio[i] - ONE_W));
         case (r_state[i])
            ST_IDLE: begin
               w_cnt_nxt[i] = {W{1'b0}};
               if (r_pending[i]) begin
                  w_ratio_nxt[i] = r_pend_div[i];
                  w_pend_nxt[i]  = 1'b0;
               end else if (w_acc[i]) begin
                  w_ratio_nxt[i] = w_cfg_val;
               end else begin
                  w_ratio_nxt[i] = r_ratio[i];
               end
               if (ch_en[i]) begin
                  w_state_nxt[i] = ST_RUN;
               end else begin
                  w_state_nxt[i] = ST_IDLE;
               end
            end
            ST_RUN, ST_DRAIN: begin
               if (w_wrap[i]) begin
                  w_cnt_nxt[i] = {W{1'b0}};
                  if (r_pending[i]) begin
                     w_ratio_nxt[i] = r_pend_div[i];
                     w_pend_nxt[i]  = 1'b0;
                  end else begin
                     w_ratio_nxt[i] = r_ratio[i];
                  end
                  w_state_nxt[i] = ch_en[i] ? ST_RUN : ST_IDLE;
               end else begin
                  w_cnt_nxt[i]   = r_cnt[i] + ONE_W;
                  w_state_nxt[i] = ch_en[i] ? ST_RUN : ST_DRAIN;
               end
               // A request landing on a wrap is held for the following wrap.
               if (w_acc[i]) begin
                  w_pdiv_nxt[i] = w_cfg_val;
                  w_pend_nxt[i] = 1'b1;
               end else begin
                  w_pdiv_nxt[i] = r_pend_div[i];
               end
            end
            default: begin
               w_state_nxt[i] = ST_IDLE;
               w_cnt_nxt[i]   = {W{1'b0}};
            end
         endcase
         w_run_nxt[i]  = (w_state_nxt[i] != ST_IDLE);
         w_half[i]     = ({1'b0, w_ratio_nxt[i]} + ONE_W1) >> 1'b1;
         w_q_p_nxt[i]  = w_run_nxt[i] & ({1'b0, w_cnt_nxt[i]} < w_half[i]);
         w_tick_nxt[i] = w_run_nxt[i] & (w_cnt_nxt[i] == (w_ratio_nxt[i] - ONE_W));
      end
   end

   // Channel state, counters, ratios and registered outputs.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < CH; i++) begin
            r_state[i]    <= ST_IDLE;
            r_cnt[i]      <= {W{1'b0}};
            r_ratio[i]    <= DIV_RST;
            r_pend_div[i] <= DIV_RST;
         end
         r_pending <= {CH{1'b0}};
         r_q_p     <= {CH{1'b0}};
         r_tick    <= {CH{1'b0}};
         r_run     <= {CH{1'b0}};
         r_cfg_err <= 1'b0;
      end else begin
         for (int i = 0; i < CH; i++) begin
            r_state[i]    <= w_state_nxt[i];
            r_cnt[i]      <= w_cnt_nxt[i];
            r_ratio[i]    <= w_ratio_nxt[i];
            r_pend_div[i] <= w_pdiv_nxt[i];
         end
         r_pending <= w_pend_nxt;
         r_q_p     <= w_q_p_nxt;
         r_tick    <= w_tick_nxt;
         r_run     <= w_run_nxt;
         r_cfg_err <= w_accept & w_cfg_short;
      end
   end

   // Half-cycle delayed copy of q_p used to stretch odd-ratio high time by half a clock.
   always_ff @(negedge clk or negedge rst) begin
      if (!rst) begin
         r_q_n <= {CH{1'b0}};
      end else begin
         r_q_n <= r_q_p;
      end
   end

   // Odd/even select follows the registered ratio, so it only switches at a wrap.
   always_comb begin
      for (int i = 0; i < CH; i++) begin
         if (r_ratio[i][0]) begin
            div_out[i] = r_q_p[i] & r_q_n[i];
         end else begin
            div_out[i] = r_q_p[i];
         end
      end
   end

   assign tick    = r_tick;
   assign running = r_run;
   assign cfg_err = r_cfg_err;

`ifdef FREQ_DIV_PERIOD_CNT_EN
   logic [15:0] r_per_cnt [CH];

   // Saturating completed-period counters, restarted whenever a channel leaves IDLE.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < CH; i++) begin
            r_per_cnt[i] <= 16'h0000;
         end
      end else begin
         for (int i = 0; i < CH; i++) begin
            if ((r_state[i] == ST_IDLE) && (w_state_nxt[i] == ST_RUN)) begin
               r_per_cnt[i] <= 16'h0000;
            end else if (r_tick[i] && (r_per_cnt[i] != 16'hFFFF)) begin
               r_per_cnt[i] <= r_per_cnt[i] + 16'd1;
            end else begin
               r_per_cnt[i] <= r_per_cnt[i];
            end
         end
      end
   end

   // Flatten the per-channel counters onto the output bus.
   always_comb begin
      for (int i = 0; i < CH; i++) begin
         per_cnt[i*16 +: 16] = r_per_cnt[i];
      end
   end
`endif

endmodule

// File: tb/tb_freq_div_prog.sv
// Directed, table-driven bench for freq_div_prog (CH=4, W=8, DEF_DIV=2) with hand-computed expectations.
module tb_freq_div_prog;
   localparam int CH = 4;
   localparam int W  = 8;

   typedef struct {
      logic [3:0] en;
      logic       v;
      logic [1:0] ch;
      logic [7:0] dv;
      logic       rdy;
      logic [3:0] dout;
      logic [3:0] tk;
      logic [3:0] run;
      logic       err;
   } vec_t;

   logic          clk = 1'b0;
   logic          rst;
   logic [CH-1:0] ch_en;
   logic          cfg_valid;
   logic [1:0]    cfg_ch;
   logic [W-1:0]  cfg_div;
   logic          cfg_ready;
   logic          cfg_err;
   logic [CH-1:0] div_out;
   logic [CH-1:0] tick;
   logic [CH-1:0] running;
`ifdef FREQ_DIV_PERIOD_CNT_EN
   logic [CH*16-1:0] per_cnt;
`endif

   int   n_vec = 0;
   int   n_bad = 0;
   vec_t tbl [20];

   always #5 clk = ~clk;

   freq_div_prog #(.CH(CH), .W(W), .DEF_DIV(2)) dut (
      .clk       (clk),
      .rst       (rst),
      .ch_en     (ch_en),
      .cfg_valid (cfg_valid),
      .cfg_ch    (cfg_ch),
      .cfg_div   (cfg_div),
      .cfg_ready (cfg_ready),
      .cfg_err   (cfg_err),
      .div_out   (div_out),
      .tick      (tick),
      .running   (running)
`ifdef FREQ_DIV_PERIOD_CNT_EN
      ,
      .per_cnt   (per_cnt)
`endif
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [3:0] en, input logic v, input logic [1:0] ch, input logic [7:0] dv);
      ch_en     = en;
      cfg_valid = v;
      cfg_ch    = ch;
      cfg_div   = dv;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   initial begin
      logic       rdy_s;
      logic [9:0] pat;
      logic [4:0] tpat;
      logic [7:0] p8;
      logic [7:0] t8;
      logic [3:0] p4;
      logic [3:0] t4;

      //               en      v     ch    dv     rdy   dout     tick     run      err
      tbl[0]  = '{4'b0000, 1'b0, 2'd1, 8'd0, 1'b1, 4'b0000, 4'b0000, 4'b0000, 1'b0};
      tbl[1]  = '{4'b0001, 1'b0, 2'd1, 8'd0, 1'b1, 4'b0001, 4'b0000, 4'b0001, 1'b0};
      tbl[2]  = '{4'b0001, 1'b0, 2'd1, 8'd0, 1'b1, 4'b0000, 4'b0001, 4'b0001, 1'b0};
      tbl[3]  = '{4'b0001, 1'b1, 2'd1, 8'd6, 1'b1, 4'b0001, 4'b0000, 4'b0001, 1'b0};
      tbl[4]  = '{4'b0011, 1'b0, 2'd1, 8'd0, 1'b1, 4'b0010, 4'b0001, 4'b0011, 1'b0};
      tbl[5]  = '{4'b0011, 1'b0, 2'd1, 8'd0, 1'b1, 4'b0011, 4'b0000, 4'b0011, 1'b0};
      tbl[6]  = '{4'b0011, 1'b0, 2'd1, 8'd0, 1'b1, 4'b0010, 4'b0001, 4'b0011, 1'b0};
      tbl[7]  = '{4'b0011, 1'b0, 2'd1, 8'd0, 1'b1, 4'b0001, 4'b0000, 4'b0011, 1'b0};
      tbl[8]  = '{4'b0011, 1'b0, 2'd1, 8'd0, 1'b1, 4'b0000, 4'b0001, 4'b0011, 1'b0};
      tbl[9]  = '{4'b0011, 1'b0, 2'd1, 8'd0, 1'b1, 4'b0001, 4'b0010, 4'b0011, 1'b0};
      tbl[10] = '{4'b0011, 1'b1, 2'd3, 8'd1, 1'b1, 4'b0010, 4'b0001, 4'b0011, 1'b1};
      tbl[11] = '{4'b1011, 1'b0, 2'd3, 8'd0, 1'b1, 4'b1011, 4'b0000, 4'b1011, 1'b0};
      tbl[12] = '{4'b0011, 1'b0, 2'd3, 8'd0, 1'b1, 4'b0010, 4'b1001, 4'b1011, 1'b0};
      tbl[13] = '{4'b0011, 1'b0, 2'd3, 8'd0, 1'b1, 4'b0001, 4'b0000, 4'b0011, 1'b0};
      tbl[14] = '{4'b0011, 1'b0, 2'd3, 8'd0, 1'b1, 4'b0000, 4'b0001, 4'b0011, 1'b0};
      tbl[15] = '{4'b0011, 1'b1, 2'd1, 8'd3, 1'b1, 4'b0001, 4'b0010, 4'b0011, 1'b0};
      tbl[16] = '{4'b0011, 1'b1, 2'd1, 8'd4, 1'b0, 4'b0000, 4'b0001, 4'b0011, 1'b0};
      tbl[17] = '{4'b0011, 1'b0, 2'd1, 8'd0, 1'b1, 4'b0011, 4'b0000, 4'b0011, 1'b0};
      tbl[18] = '{4'b0011, 1'b0, 2'd1, 8'd0, 1'b1, 4'b0000, 4'b0011, 4'b0011, 1'b0};
      tbl[19] = '{4'b0011, 1'b0, 2'd1, 8'd0, 1'b1, 4'b0001, 4'b0000, 4'b0011, 1'b0};

      rst = 1'b1;
      drive(4'b0000, 1'b0, 2'd0, 8'd0);
      #1 rst = 1'b0;
      #10;
      check("reset_state", {19'd0, div_out, tick, running, cfg_err}, 32'd0);
      check("reset_ready", {31'd0, cfg_ready}, 32'd1);
      @(negedge clk);
      rst = 1'b1;
      step();

      for (int k = 0; k < 20; k++) begin
         drive(tbl[k].en, tbl[k].v, tbl[k].ch, tbl[k].dv);
         #1;
         rdy_s = cfg_ready;
         step();
         n_vec++;
         if ({rdy_s, div_out, tick, running, cfg_err} !==
             {tbl[k].rdy, tbl[k].dout, tbl[k].tk, tbl[k].run, tbl[k].err}) begin
            n_bad++;
            $display("FAIL vec%0d: got rdy=%b div=%b tick=%b run=%b err=%b expected rdy=%b div=%b tick=%b run=%b err=%b",
                     k, rdy_s, div_out, tick, running, cfg_err,
                     tbl[k].rdy, tbl[k].dout, tbl[k].tk, tbl[k].run, tbl[k].err);
         end
      end

      // Ratio 5 on ch2: 2.5-clk high time, sampled on both edges over 10 periods.
      drive(4'b0011, 1'b1, 2'd2, 8'd5);
      step();
      drive(4'b0111, 1'b0, 2'd2, 8'd0);
      step();
      for (int p = 0; p < 10; p++) begin
         pat  = 10'd0;
         tpat = 5'd0;
         for (int c = 0; c < 5; c++) begin
            pat[2*c] = div_out[2];
            tpat[c]  = tick[2];
            @(negedge clk);
            #1;
            pat[2*c+1] = div_out[2];
            step();
         end
         check($sformatf("odd5_shape_p%0d", p), {22'd0, pat}, {22'd0, 10'b0000111110});
         check($sformatf("odd5_tick_p%0d", p), {27'd0, tpat}, {27'd0, 5'b10000});
      end

      // Config to idle ch3 in the same cycle its enable rises: ratio 4 governs the first period.
      drive(4'b1111, 1'b1, 2'd3, 8'd4);
      step();
      drive(4'b1111, 1'b0, 2'd3, 8'd0);
      for (int c = 0; c < 8; c++) begin
         p8[c] = div_out[3];
         t8[c] = tick[3];
         step();
      end
      check("simul_cfg_en_div", {24'd0, p8}, {24'd0, 8'b00110011});
      check("simul_cfg_en_tick", {24'd0, t8}, {24'd0, 8'b10001000});

      // Accept exactly on a wrap: the new ratio waits for the following wrap.
      step();
      step();
      step();
      drive(4'b1111, 1'b1, 2'd3, 8'd2);
      step();
      drive(4'b1111, 1'b0, 2'd3, 8'd0);
      #1;
      check("wrap_accept_ready", {31'd0, cfg_ready}, 32'd0);
      for (int c = 0; c < 8; c++) begin
         p8[c] = div_out[3];
         t8[c] = tick[3];
         step();
      end
      check("wrap_accept_div", {24'd0, p8}, {24'd0, 8'b01010011});
      check("wrap_accept_tick", {24'd0, t8}, {24'd0, 8'b10101000});

      // Asynchronous reset between clock edges, then ch1 restarts at the default ratio.
      #2;
      rst = 1'b0;
      ch_en = 4'b0000;
      #1;
      check("async_reset_outs", {19'd0, div_out, tick, running, cfg_err}, 32'd0);
      check("async_reset_ready", {31'd0, cfg_ready}, 32'd1);
      @(negedge clk);
      rst = 1'b1;
      step();
      drive(4'b0010, 1'b0, 2'd1, 8'd0);
      step();
      for (int c = 0; c < 4; c++) begin
         p4[c] = div_out[1];
         t4[c] = tick[1];
         step();
      end
      check("post_reset_div", {28'd0, p4}, {28'd0, 4'b0101});
      check("post_reset_tick", {28'd0, t4}, {28'd0, 4'b1010});

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule
